// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined bitwise logic unit.
//   OP_W     : opcode width in bits
//   opcode_t : per-transaction gate selection (OP_RSVD flags an error)
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOT  = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } opcode_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the command, result and counter signals of logic_unit_pipe.
//   slave  : the logic unit itself
//   master : command source / result consumer (and counter control)
//
// Handshake: a beat transfers on a rising clk edge when valid and ready are
// both 1 on that side. A source holding valid may change or drop it freely
// before the transfer; data is only sampled on the transfer edge. in_ready is
// a combinational function of the output register state and out_ready.
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic             in_chain;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;
    logic             out_err;

    logic             cnt_clr;
    logic [CNT_W-1:0] txn_count;

    modport slave (
        input  in_valid, in_op, in_chain, in_a, in_b, out_ready, cnt_clr,
        output in_ready, out_valid, out_y, out_zero, out_parity, out_err,
               txn_count
    );

    modport master (
        output in_valid, in_op, in_chain, in_a, in_b, out_ready, cnt_clr,
        input  in_ready, out_valid, out_y, out_zero, out_parity, out_err,
               txn_count
    );

endinterface

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational gate function selected by opcode.
//   op  : opcode (logic_unit_pkg::opcode_t encoding)
//   a   : operand A
//   bo  : effective operand B (already muxed with the chained result)
//   y   : bitwise result; 0 for the reserved opcode
//   err : 1 when the reserved opcode was used
// -----------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bo,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (opcode_t'(op))
            OP_AND:  y = a & bo;
            OP_OR:   y = a | bo;
            OP_NAND: y = ~(a & bo);
            OP_NOT:  y = ~bo;
            OP_NOR:  y = ~(a | bo);
            OP_XOR:  y = a ^ bo;
            OP_XNOR: y = ~(a ^ bo);
            OP_RSVD: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with valid/ready on both sides.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : logic_unit_pipe_if slave port
//         in_*      command side (opcode, chain select, operands)
//         out_*     one-stage result register plus zero/parity/err flags
//         cnt_clr   synchronous clear of txn_count (wins over increment)
//         txn_count saturating count of completed output handshakes
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    logic_unit_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept_in;
    logic             accept_out;
    logic             ready;
    logic [WIDTH-1:0] bo;
    logic [WIDTH-1:0] core_y;
    logic             core_err;

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             err_q;
    logic [WIDTH-1:0] last_y;
    logic [CNT_W-1:0] cnt_q;

    // The output register can take a new beat when empty or when its
    // current beat leaves in the same cycle, so continuous out_ready
    // gives one transaction per clock with no bubble.
    assign ready      = ~valid_q | bus.out_ready;
    assign accept_in  = bus.in_valid & ready;
    assign accept_out = valid_q & bus.out_ready;

    // last_y is written on every accept, so a transaction accepted on the
    // very next edge already sees its predecessor's result here.
    assign bo = bus.in_chain ? last_y : bus.in_b;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op  (bus.in_op),
        .a   (bus.in_a),
        .bo  (bo),
        .y   (core_y),
        .err (core_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            last_y  <= '0;
        end else if (accept_in) begin
            valid_q <= 1'b1;
            y_q     <= core_y;
            err_q   <= core_err;
            last_y  <= core_y;
        end else if (accept_out) begin
            // Data holds its last value once consumed; only valid drops.
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (accept_out && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_y      = y_q;
    // Flags follow the registered result, so they reset to zero=1 parity=0.
    assign bus.out_zero   = (y_q == '0);
    assign bus.out_parity = ^y_q;
    assign bus.out_err    = err_q;
    assign bus.txn_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=2). Expected results are
// hand-computed in the stimulus calls and queued on input acceptance; a
// monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int EW    = WIDTH + 3;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // {err, parity, zero, y}
    logic [EW-1:0] exp_q[$];

    logic_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_y",      32'(bus.out_y),      32'd0);
        check("rst_out_zero",   32'(bus.out_zero),   32'd1);
        check("rst_out_parity", 32'(bus.out_parity), 32'd0);
        check("rst_out_err",    32'(bus.out_err),    32'd0);
        check("rst_txn_count",  32'(bus.txn_count),  32'd0);
    endtask

    // Returns at posedge+1 with rst released.
    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_chain = 1'b0;
        bus.cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1. Presents one command, waits for acceptance,
    // queues the expected result and checks it one cycle after the accept.
    task automatic send(input logic [2:0] op, input logic chain,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_y, input logic exp_err);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_chain = chain;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("send_accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back({exp_err, ^exp_y, (exp_y == '0), exp_y});
        @(posedge clk);
        #1;
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("latency_out_y",     32'(bus.out_y),     32'(exp_y));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_chain = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("mon_y",      32'(bus.out_y),      32'(e[WIDTH-1:0]));
                check("mon_zero",   32'(bus.out_zero),   32'(e[WIDTH]));
                check("mon_parity", 32'(bus.out_parity), 32'(e[WIDTH+1]));
                check("mon_err",    32'(bus.out_err),    32'(e[WIDTH+2]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_chain  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        bus.cnt_clr   = 1'b0;

        #1;
        check_reset_state();
        do_reset();

        // All ops, a=F0 b=CC, back to back
        send(3'd0, 1'b0, 8'hF0, 8'hCC, 8'hC0, 1'b0);
        send(3'd1, 1'b0, 8'hF0, 8'hCC, 8'hFC, 1'b0);
        send(3'd2, 1'b0, 8'hF0, 8'hCC, 8'h3F, 1'b0);
        send(3'd3, 1'b0, 8'hF0, 8'hCC, 8'h33, 1'b0);
        send(3'd4, 1'b0, 8'hF0, 8'hCC, 8'h03, 1'b0);
        send(3'd5, 1'b0, 8'hF0, 8'hCC, 8'h3C, 1'b0);
        send(3'd6, 1'b0, 8'hF0, 8'hCC, 8'hC3, 1'b0);
        idle(2);

        // Reserved opcode, then AND with the same operands
        send(3'd7, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1);
        send(3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        idle(2);

        // Back-to-back chaining
        send(3'd5, 1'b0, 8'h0F, 8'hF0, 8'hFF, 1'b0);
        send(3'd5, 1'b1, 8'h01, 8'h55, 8'hFE, 1'b0);
        idle(2);

        // Backpressure
        do_reset();
        send(3'd0, 1'b0, 8'hF0, 8'hCC, 8'hC0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd5;
        bus.in_chain  = 1'b0;
        bus.in_a      = 8'hF0;
        bus.in_b      = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_y",     32'(bus.out_y),     32'hC0);
        end
        @(posedge clk);
        #1;
        check("stall_out_y_held", 32'(bus.out_y),     32'hC0);
        check("stall_count",      32'(bus.txn_count), 32'd0);
        bus.out_ready = 1'b1;
        send(3'd5, 1'b0, 8'hF0, 8'hCC, 8'h3C, 1'b0);
        check("release_count", 32'(bus.txn_count), 32'd1);
        idle(2);

        // Saturating counter and clear priority
        do_reset();
        send(3'd0, 1'b0, 8'hF0, 8'hCC, 8'hC0, 1'b0);
        send(3'd1, 1'b0, 8'hF0, 8'hCC, 8'hFC, 1'b0);
        send(3'd2, 1'b0, 8'hF0, 8'hCC, 8'h3F, 1'b0);
        send(3'd3, 1'b0, 8'hF0, 8'hCC, 8'h33, 1'b0);
        send(3'd4, 1'b0, 8'hF0, 8'hCC, 8'h03, 1'b0);
        send(3'd5, 1'b0, 8'hF0, 8'hCC, 8'h3C, 1'b0);
        check("cnt_saturated", 32'(bus.txn_count), 32'd3);
        bus.cnt_clr = 1'b1;
        idle(1);
        bus.cnt_clr = 1'b0;
        check("cnt_clr_priority", 32'(bus.txn_count), 32'd0);
        check("cnt_clr_drained",  32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-stream
        do_reset();
        send(3'd5, 1'b0, 8'h0F, 8'hF0, 8'hFF, 1'b0);
        idle(1);
        check("pre_rst_count", 32'(bus.txn_count), 32'd1);
        bus.out_ready = 1'b0;
        send(3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_count",     32'(bus.txn_count), 32'd0);
        check("async_rst_out_y",     32'(bus.out_y),     32'd0);
        check("async_rst_zero",      32'(bus.out_zero),  32'd1);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(3'd1, 1'b1, 8'h00, 8'hAA, 8'h00, 1'b0);
        check("chain_after_rst_zero", 32'(bus.out_zero), 32'd1);
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit; successor to the team's fixed 1-bit gate block.
- Applies one of seven gate functions (selected per transaction by opcode) to WIDTH-bit operands.
- Valid/ready handshake on both sides, one output register stage, result flags, optional chaining of the previous result, saturating transaction counter.
- Sits between a command source and a downstream consumer in the datapath test fabric.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of transaction counter (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- in_op  in  3  opcode (see Behaviour)
- in_chain  in  1  1 = use last result in place of in_b
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result register holds valid data
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_zero  out  1  out_y == 0
- out_parity  out  1  XOR-reduction of out_y (1 = odd number of ones)
- out_err  out  1  transaction used reserved opcode
- cnt_clr  in  1  synchronous clear of txn_count
- txn_count  out  CNT_W  completed output handshakes, saturating

Behaviour:
- Reset: asynchronous, active-high.
  - While rst is high: out_valid=0, out_y=0, out_zero=1, out_parity=0, out_err=0, txn_count=0, last_y=0.
  - in_ready is 1 immediately after reset (out_valid=0).
- Opcodes, with bo = effective B:
  - 0 AND a&bo
  - 1 OR a|bo
  - 2 NAND ~(a&bo)
  - 3 NOT ~bo (A ignored)
  - 4 NOR ~(a|bo)
  - 5 XOR a^bo
  - 6 XNOR ~(a^bo)
  - 7 reserved: y=0, err=1
- Effective B: bo = in_chain ? last_y : in_b.
  - last_y is an internal register loaded with y on every input accept, including reserved-op transactions, which load 0.
- Handshake:
  - accept_in = in_valid & in_ready.
  - accept_out = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready (combinational; full throughput with continuous out_ready).
- Latency: 1 cycle. Operands accepted at edge N appear on out_y with out_valid=1 after edge N.
- Output register update:
  - accept_in: load y, zero, parity, err; out_valid<=1.
  - accept_out without accept_in: out_valid<=0; data holds its last value.
  - Neither: all output registers hold.
- Stall: while out_valid=1 and out_ready=0, out_y and the flags are stable and in_ready=0.
- Simultaneous accept_out and accept_in in one cycle: the new result replaces the old; out_valid stays 1; no bubble.
- Chaining is back-to-back safe: a transaction accepted on the cycle after its predecessor sees the predecessor's y in last_y.
- Flags are computed from the registered result, not from inputs. out_err is per-transaction, not sticky.
- txn_count:
  - Increments on accept_out.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets it to 0 and takes priority over increment in the same cycle.
- Reset mid-stream: the pending output is discarded and the counter is cleared; no partial transaction survives.
- in_valid may drop without acceptance; no protocol assertion on the input side.
- Width rules: all operations are purely bitwise at WIDTH; no carries; X-free outputs after reset.

Decomposition:
- Package logic_unit_pkg:
  - opcode enum (OP_AND..OP_XNOR, OP_RSVD)
  - opcode width constant (3)
- One sub-module, logic_unit_core: combinational; inputs op, a, bo (WIDTH); outputs y and err.
- logic_unit_pipe holds the handshake, output register, flags, last_y and counter.

Test Plan:
- All ops, WIDTH=8, a=0xF0, b=0xCC, out_ready=1:
  - expected y: AND 0xC0, OR 0xFC, NAND 0x3F, NOT 0x33, NOR 0x03, XOR 0x3C, XNOR 0xC3
  - each result one cycle after accept
  - parity=0 for each of these results
- Reserved op 7 with a=0xFF, b=0xFF -> y=0x00, zero=1, err=1. Next op AND with the same operands -> y=0xFF, err=0, parity=0.
- Chain: XOR a=0x0F, b=0xF0 (y=0xFF), then accepted next cycle XOR a=0x01, chain=1 -> y=0xFE, parity=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_y stable, no input consumed. Release -> old result handshakes, new accepted same cycle, txn_count +1.
- Counter (CNT_W=2): 5 output handshakes -> txn_count=3 (saturated). Assert cnt_clr together with a handshake -> txn_count=0.
- Assert rst asynchronously between clock edges while out_valid=1 -> out_valid=0, txn_count=0 immediately. After release, a chained op uses last_y=0: OR a=0x00, chain=1 -> y=0x00, zero=1.
